memory_access: RTL and testbench

- MEM pipeline stage. Consumes the EX/MEM register outputs of the execute stage and performs loads and stores on a req/gnt/rvalid data-memory bus.
- Produces the MEM/WB register: aligned, extended load data, or the ALU result passed through unchanged.
- Raises a stall while a memory access is outstanding.

---
 rtl/riscv_pkg.sv | 51 +++++
 rtl/load_align.sv | 36 +++
 rtl/memory_access.sv | 200 ++++++++++++++++++++
 tb/tb_memory_access.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared core types: datapath width, decoded operation encoding, the register
//   write-back port carried down the pipeline, and the MEM-stage bus FSM and
//   access-size encodings.
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN = 32;

  // UNKNOWN is encoding 0 so a cleared pipeline register decodes as a bubble.
  typedef enum logic [4:0] {
    UNKNOWN,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, ADD, SUB, AND, OR, XOR
  } operation_e;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
    logic            valid;
  } rd_port_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID
  } mem_state_e;

  typedef enum logic [1:0] {
    BYTE,
    HALF,
    WORD
  } mem_size_e;

  function automatic logic is_load_op(input operation_e op);
    return op inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic mem_size_e op_size(input operation_e op);
    case (op)
      LB, LBU, SB: return BYTE;
      LH, LHU, SH: return HALF;
      default:     return WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
//   Selects the addressed byte/half/word lane out of a bus read word and
//   sign- or zero-extends it according to the load operation.
//   rdata_i     : raw word from the data bus
//   offset_i    : ea[1:0] of the load
//   operation_i : LB/LH/LW/LBU/LHU (anything else passes the lane through)
//   data_o      : extended XLEN result
// -----------------------------------------------------------------------------
module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      offset_i,
  input  operation_e      operation_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] lane;

  assign lane = rdata_i >> {offset_i, 3'b000};

  // NOTE: data_o is given a value before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    data_o = lane;
    case (operation_i)
      LB:      data_o = {{(XLEN-8){lane[7]}},   lane[7:0]};
      LBU:     data_o = {{(XLEN-8){1'b0}},      lane[7:0]};
      LH:      data_o = {{(XLEN-16){lane[15]}}, lane[15:0]};
      LHU:     data_o = {{(XLEN-16){1'b0}},     lane[15:0]};
      default: data_o = lane;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
//   MEM pipeline stage. Issues loads/stores on a req/gnt/rvalid data bus,
//   stalls upstream while an access is outstanding and registers MEM/WB.
//   clk_i, rstn_i          : clock, asynchronous active-low reset
//   pcM_i .. rdM_port_i    : EX/MEM register contents
//   memM_wrt_ena_i         : store request
//   memM_wrt_data_i        : effective address (rs1+imm) -- historical name
//   memM_wrt_addr_i        : store data (rs2)            -- historical name
//   dmem_*                 : data-memory bus
//   stallM_o               : combinational stall for IF..EX and EX/MEM
//   pcM_o .. rdM_port_o    : MEM/WB register
//   misaligned_o/bus_err_o : one-cycle exception pulses
// -----------------------------------------------------------------------------
module memory_access
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [XLEN-1:0] pcM_i,
  input  logic [XLEN-1:0] instrM_i,
  input  operation_e      operationM_i,
  input  rd_port_t        rdM_port_i,
  input  logic            memM_wrt_ena_i,
  input  logic [XLEN-1:0] memM_wrt_data_i,
  input  logic [XLEN-1:0] memM_wrt_addr_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            stallM_o,
  output logic [XLEN-1:0] pcM_o,
  output logic [XLEN-1:0] instrM_o,
  output operation_e      operationM_o,
  output rd_port_t        rdM_port_o,
  output logic            misaligned_o,
  output logic            bus_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] ea, rs2, load_data;
  mem_size_e       size;
  logic            is_load, is_store, access, misaligned, misaligned_hit;
  logic            req, stall, complete, abort, timeout_hit;
  rd_port_t        wb_rd;

  assign ea       = memM_wrt_data_i;
  assign rs2      = memM_wrt_addr_i;
  assign size     = op_size(operationM_i);
  assign is_store = memM_wrt_ena_i;
  assign is_load  = is_load_op(operationM_i) && rdM_port_i.valid;
  assign access   = is_load || is_store;

  assign misaligned = access && (((size == WORD) && (ea[1:0] != 2'b00)) ||
                                 ((size == HALF) && ea[0]));
  assign misaligned_hit = (state_q == IDLE) && misaligned;

  // Address/strobes/data come straight from EX/MEM, which the stall freezes,
  // so they stay stable for the whole WAIT_GNT period without extra flops.
  assign dmem_we_o   = is_store;
  assign dmem_addr_o = {ea[XLEN-1:2], 2'b00};

  always_comb begin
    dmem_be_o    = 4'b1111;
    dmem_wdata_o = rs2;
    case (size)
      BYTE: begin
        dmem_be_o    = 4'b0001 << ea[1:0];
        dmem_wdata_o = {4{rs2[7:0]}};
      end
      HALF: begin
        dmem_be_o    = 4'b0011 << {ea[1], 1'b0};
        dmem_wdata_o = {2{rs2[15:0]}};
      end
      default: begin
        dmem_be_o    = 4'b1111;
        dmem_wdata_o = rs2;
      end
    endcase
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next state and bus/stall outputs. Completion takes priority over timeout.
  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    stall    = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && !misaligned) begin
          req = 1'b1;
          if (dmem_gnt_i && is_store) begin
            complete = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = dmem_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        req = 1'b1;
        if (dmem_gnt_i && is_store) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          if (dmem_gnt_i) state_d = WAIT_RVALID;
        end
      end
      WAIT_RVALID: begin
        if (dmem_rvalid_i) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset must silence the bus and release the pipeline immediately, even
  // though the EX/MEM inputs may still describe an access.
  assign dmem_req_o = req   && rstn_i;
  assign stallM_o   = stall && rstn_i;

  load_align u_load_align (
    .rdata_i     (dmem_rdata_i),
    .offset_i    (ea[1:0]),
    .operation_i (operationM_i),
    .data_o      (load_data)
  );

  always_comb begin
    wb_rd = rdM_port_i;
    if (complete && !is_store) begin
      wb_rd = '{addr: rdM_port_i.addr, data: load_data, valid: 1'b1};
    end else if (is_store || misaligned_hit || abort) begin
      wb_rd.valid = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // Counts cycles spent in WAIT_GNT + WAIT_RVALID for one access.
      if (state_q == IDLE || state_d == IDLE) cnt_q <= '0;
      else                                    cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pcM_o        <= '0;
      instrM_o     <= '0;
      operationM_o <= UNKNOWN;
      rdM_port_o   <= '0;
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      misaligned_o <= misaligned_hit;
      bus_err_o    <= abort;
      if (stall) begin
        pcM_o        <= '0;
        instrM_o     <= '0;
        operationM_o <= UNKNOWN;
        rdM_port_o   <= '0;
      end else begin
        pcM_o        <= pcM_i;
        instrM_o     <= instrM_i;
        operationM_o <= operationM_i;
        rdM_port_o   <= wb_rd;
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// -----------------------------------------------------------------------------
// tb_memory_access
//   Directed bench for the MEM stage with TIMEOUT_CYCLES = 8.
// -----------------------------------------------------------------------------
module tb_memory_access;
  import riscv_pkg::*;

  logic            clk_i = 1'b0;
  logic            rstn_i;
  logic [XLEN-1:0] pcM_i, instrM_i;
  operation_e      operationM_i;
  rd_port_t        rdM_port_i;
  logic            memM_wrt_ena_i;
  logic [XLEN-1:0] memM_wrt_data_i, memM_wrt_addr_i;
  logic            dmem_req_o, dmem_we_o;
  logic [XLEN-1:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]      dmem_be_o;
  logic            dmem_gnt_i, dmem_rvalid_i;
  logic [XLEN-1:0] dmem_rdata_i;
  logic            stallM_o;
  logic [XLEN-1:0] pcM_o, instrM_o;
  operation_e      operationM_o;
  rd_port_t        rdM_port_o;
  logic            misaligned_o, bus_err_o;

  int errors = 0;
  int checks = 0;

  memory_access #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .pcM_i           (pcM_i),
    .instrM_i        (instrM_i),
    .operationM_i    (operationM_i),
    .rdM_port_i      (rdM_port_i),
    .memM_wrt_ena_i  (memM_wrt_ena_i),
    .memM_wrt_data_i (memM_wrt_data_i),
    .memM_wrt_addr_i (memM_wrt_addr_i),
    .dmem_req_o      (dmem_req_o),
    .dmem_we_o       (dmem_we_o),
    .dmem_addr_o     (dmem_addr_o),
    .dmem_be_o       (dmem_be_o),
    .dmem_wdata_o    (dmem_wdata_o),
    .dmem_gnt_i      (dmem_gnt_i),
    .dmem_rvalid_i   (dmem_rvalid_i),
    .dmem_rdata_i    (dmem_rdata_i),
    .stallM_o        (stallM_o),
    .pcM_o           (pcM_o),
    .instrM_o        (instrM_o),
    .operationM_o    (operationM_o),
    .rdM_port_o      (rdM_port_o),
    .misaligned_o    (misaligned_o),
    .bus_err_o       (bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_ex(input operation_e op, input logic [4:0] rd, input logic [31:0] rd_data,
                        input logic rd_valid, input logic st, input logic [31:0] ea,
                        input logic [31:0] rs2);
    pcM_i           = pcM_i + 32'd4;
    instrM_i        = ~pcM_i;
    operationM_i    = op;
    rdM_port_i      = '{addr: rd, data: rd_data, valid: rd_valid};
    memM_wrt_ena_i  = st;
    memM_wrt_data_i = ea;
    memM_wrt_addr_i = rs2;
  endtask

  // Half-word load at 0x2002: gnt in cycle 2, rvalid in cycle 4.
  task automatic half_load(input operation_e op, input logic [31:0] exp_data);
    int n;
    rd_port_t exp_rd;
    exp_rd = '{addr: 5'd7, data: exp_data, valid: 1'b1};
    set_ex(op, 5'd7, 32'h0, 1'b1, 1'b0, 32'h0000_2002, 32'h0);
    n = 0;
    for (int c = 0; c < 5; c++) begin
      dmem_gnt_i    = (c == 2);
      dmem_rvalid_i = (c == 4);
      dmem_rdata_i  = (c == 4) ? 32'h8001_7FFF : 32'hDEAD_BEEF;
      #1;
      if (c == 0) begin
        check("ld_req", dmem_req_o, 1);
        check("ld_addr", dmem_addr_o, 32'h0000_2000);
        check("ld_we", dmem_we_o, 0);
      end
      if (c == 2) check("ld_bubble_valid", rdM_port_o.valid, 0);
      if (c == 3) check("ld_req_in_wait_rvalid", dmem_req_o, 0);
      if (stallM_o) n++;
      if (c < 4) tick();
    end
    check("ld_stall_cycles", n, 4);
    tick();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    check("ld_rd_port", rdM_port_o, exp_rd);
    check("ld_operation", operationM_o, op);
  endtask

  initial begin
    int n;
    logic [31:0] exp_pc;
    rd_port_t exp_rd;

    rstn_i        = 1'b0;
    pcM_i         = 32'h0000_0100;
    instrM_i      = 32'h0;
    operationM_i  = UNKNOWN;
    rdM_port_i    = '0;
    memM_wrt_ena_i  = 1'b0;
    memM_wrt_data_i = 32'h0;
    memM_wrt_addr_i = 32'h0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'h0;

    // Reset state
    #1;
    check("rst_req", dmem_req_o, 0);
    check("rst_stall", stallM_o, 0);
    check("rst_rd_port", rdM_port_o, 0);
    check("rst_operation", operationM_o, UNKNOWN);
    check("rst_pulses", {misaligned_o, bus_err_o}, 0);
    #11 rstn_i = 1'b1;
    tick();

    // Pass-through ADD
    set_ex(ADD, 5'd5, 32'h0000_1234, 1'b1, 1'b0, 32'h0, 32'h0);
    exp_pc = pcM_i;
    exp_rd = '{addr: 5'd5, data: 32'h0000_1234, valid: 1'b1};
    #1;
    check("add_req", dmem_req_o, 0);
    check("add_stall", stallM_o, 0);
    tick();
    check("add_rd_port", rdM_port_o, exp_rd);
    check("add_pc", pcM_o, exp_pc);
    check("add_operation", operationM_o, ADD);

    // SB with same-cycle grant
    set_ex(SB, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0000_1003, 32'hAABB_CCDD);
    dmem_gnt_i = 1'b1;
    #1;
    check("sb_req", dmem_req_o, 1);
    check("sb_we", dmem_we_o, 1);
    check("sb_addr", dmem_addr_o, 32'h0000_1000);
    check("sb_be", dmem_be_o, 4'b1000);
    check("sb_wdata", dmem_wdata_o, 32'hDDDD_DDDD);
    check("sb_stall", stallM_o, 0);
    tick();
    dmem_gnt_i = 1'b0;
    check("sb_wb_valid", rdM_port_o.valid, 0);
    check("sb_operation", operationM_o, SB);

    // Half-word loads, signed then unsigned
    half_load(LH,  32'hFFFF_8001);
    half_load(LHU, 32'h0000_8001);

    // Misaligned LW
    set_ex(LW, 5'd3, 32'h0, 1'b1, 1'b0, 32'h0000_0006, 32'h0);
    #1;
    check("mis_req", dmem_req_o, 0);
    check("mis_stall", stallM_o, 0);
    tick();
    check("mis_pulse", misaligned_o, 1);
    check("mis_wb_valid", rdM_port_o.valid, 0);
    set_ex(ADD, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("mis_pulse_end", misaligned_o, 0);

    // Timeout: LW never granted
    set_ex(LW, 5'd9, 32'h0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!stallM_o) break;
      n++;
      tick();
    end
    check("to_stall_cycles", n, 8);
    tick();
    check("to_bus_err", bus_err_o, 1);
    check("to_wb_valid", rdM_port_o.valid, 0);
    set_ex(ADD, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hCAFE_F00D;
    #1;
    check("to_late_req", dmem_req_o, 0);
    check("to_late_stall", stallM_o, 0);
    tick();
    dmem_rvalid_i = 1'b0;
    check("to_bus_err_end", bus_err_o, 0);
    check("to_late_wb_valid", rdM_port_o.valid, 0);
    set_ex(ADD, 5'd1, 32'h0000_0055, 1'b1, 1'b0, 32'h0, 32'h0);
    exp_rd = '{addr: 5'd1, data: 32'h0000_0055, valid: 1'b1};
    #1;
    check("to_idle_stall", stallM_o, 0);
    tick();
    check("to_idle_rd_port", rdM_port_o, exp_rd);

    // Reset while waiting for rvalid
    set_ex(LW, 5'd4, 32'h0, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
    dmem_gnt_i = 1'b1;
    #1;
    check("rr_stall_issue", stallM_o, 1);
    tick();
    dmem_gnt_i = 1'b0;
    #1;
    check("rr_wait_req", dmem_req_o, 0);
    check("rr_wait_stall", stallM_o, 1);
    #2 rstn_i = 1'b0;
    #1;
    check("rr_req", dmem_req_o, 0);
    check("rr_stall", stallM_o, 0);
    check("rr_rd_port", rdM_port_o, 0);
    check("rr_operation", operationM_o, UNKNOWN);
    check("rr_pc", pcM_o, 0);
    set_ex(ADD, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2 rstn_i = 1'b1;
    tick();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h1234_5678;
    #1;
    check("rr_stray_req", dmem_req_o, 0);
    tick();
    dmem_rvalid_i = 1'b0;
    check("rr_stray_wb_valid", rdM_port_o.valid, 0);
    check("rr_stray_stall", stallM_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
